// File: rtl/dff_bank_arbiter_if.sv
// Bus between the requesters / shared D register and the bank arbiter.
// The master side drives requests and the register readback; the slave
// side (the arbiter) drives grants, register controls and completion.
interface dff_bank_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 3
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic [ID_W-1:0]           grant_id;
    logic [DATA_W-1:0]         ff_d;
    logic                      ff_enable;
    logic [DATA_W-1:0]         ff_out;
    logic                      busy;
    logic                      done;
    logic                      err;

    modport master (
        output req, req_data, ff_out,
        input  grant, grant_id, ff_d, ff_enable, busy, done, err
    );

    modport slave (
        input  req, req_data, ff_out,
        output grant, grant_id, ff_d, ff_enable, busy, done, err
    );
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sharing one enable-gated D register among NUM_REQ
// requesters. Each transaction writes the winner's data, reads the register
// back one cycle later, and reports done/err to the winner. Every output is
// registered; the priority pointer only moves when a transaction completes.
module dff_bank_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 3
) (
    input logic               clk,
    input logic               reset,
    dff_bank_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [NUM_REQ-1:0]  grant_q, grant_nxt;
    logic [ID_W-1:0]     grant_id_q, grant_id_nxt;
    logic [ID_W-1:0]     ptr_q, ptr_nxt;
    logic [DATA_W-1:0]   ff_d_q, ff_d_nxt;
    logic                ff_enable_q, ff_enable_nxt;
    logic                busy_q, busy_nxt;
    logic                done_q, done_nxt;
    logic                err_q, err_nxt;

    logic                win_found;
    logic [ID_W-1:0]     win_idx;

    // Pick the first asserted request scanning ptr+1, ptr+2, ... modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!win_found && bus.req[i] &&
                    (i == ((int'(ptr_q) + k) % NUM_REQ))) begin
                    win_found = 1'b1;
                    win_idx   = ID_W'(i);
                end
            end
        end
    end

    // State and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            grant_q     <= '0;
            grant_id_q  <= '0;
            ptr_q       <= ID_W'(NUM_REQ - 1);
            ff_d_q      <= '0;
            ff_enable_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant_q     <= grant_nxt;
            grant_id_q  <= grant_id_nxt;
            ptr_q       <= ptr_nxt;
            ff_d_q      <= ff_d_nxt;
            ff_enable_q <= ff_enable_nxt;
            busy_q      <= busy_nxt;
            done_q      <= done_nxt;
            err_q       <= err_nxt;
        end
    end

    // Next-state sequencing: IDLE -> WRITE -> VERIFY -> DONE -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (win_found) state_nxt = ST_WRITE;
            ST_WRITE:  state_nxt = ST_VERIFY;
            ST_VERIFY: state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; anything not touched holds.
    always_comb begin
        grant_nxt     = grant_q;
        grant_id_nxt  = grant_id_q;
        ptr_nxt       = ptr_q;
        ff_d_nxt      = ff_d_q;
        ff_enable_nxt = ff_enable_q;
        busy_nxt      = busy_q;
        done_nxt      = done_q;
        err_nxt       = err_q;
        case (state)
            ST_IDLE: begin
                if (win_found) begin
                    // Data is latched here so later req_data changes cannot leak in.
                    for (int i = 0; i < NUM_REQ; i++) begin
                        grant_nxt[i] = (win_idx == ID_W'(i));
                        if (win_idx == ID_W'(i)) begin
                            ff_d_nxt = bus.req_data[i*DATA_W +: DATA_W];
                        end
                    end
                    grant_id_nxt  = win_idx;
                    ff_enable_nxt = 1'b1;
                    busy_nxt      = 1'b1;
                end
            end
            ST_WRITE: begin
                ff_enable_nxt = 1'b0;
            end
            ST_VERIFY: begin
                // The register captured ff_d at the end of WRITE, so out is settled now.
                done_nxt = 1'b1;
                err_nxt  = (bus.ff_out != ff_d_q);
                ptr_nxt  = grant_id_q;
            end
            ST_DONE: begin
                grant_nxt = '0;
                done_nxt  = 1'b0;
                err_nxt   = 1'b0;
                busy_nxt  = 1'b0;
            end
            default: begin
                grant_nxt     = '0;
                ff_enable_nxt = 1'b0;
                busy_nxt      = 1'b0;
                done_nxt      = 1'b0;
                err_nxt       = 1'b0;
            end
        endcase
    end

    assign bus.grant     = grant_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.ff_d      = ff_d_q;
    assign bus.ff_enable = ff_enable_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Bench for dff_bank_arbiter: directed scenarios plus a randomized run checked
// against a round-robin reference model and a behavioural shared register.
module tb_dff_bank_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ID_W    = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dff_bank_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus();

    dff_bank_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Shared enable-gated register; 'stuck' models a dead enable with out forced low.
    logic [DATA_W-1:0] ff_q = '0;
    logic              stuck = 1'b0;
    always @(posedge clk) if (bus.ff_enable && !stuck) ff_q <= bus.ff_d;
    assign bus.ff_out = stuck ? '0 : ff_q;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int ptr_m = NUM_REQ - 1;

    function automatic int rr_pick(int p, logic [NUM_REQ-1:0] r);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_data(input int i, input logic [DATA_W-1:0] v);
        bus.req_data[i*DATA_W +: DATA_W] = v;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.req = '0;
        bus.req_data = 32'h44332211;
        repeat (2) tick();
        tests++;
        if ({bus.grant, bus.grant_id, bus.ff_d, bus.ff_enable, bus.busy, bus.done, bus.err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got grant=%b id=%0d d=%h en=%b busy=%b done=%b err=%b want all zero",
                     bus.grant, bus.grant_id, bus.ff_d, bus.ff_enable, bus.busy, bus.done, bus.err);
        end
        reset = 1'b1;
        tick();
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_no_req_busy: got %b want 0", bus.busy);
        end
        bus.req = 4'b1111;
        tick();
        tests++;
        if (bus.grant !== 4'b0001) begin
            fails++;
            $display("FAIL reset_first_grant: got %b want 0001", bus.grant);
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({bus.grant, bus.ff_enable, bus.busy} !== 6'b0) begin
            fails++;
            $display("FAIL async_abort: got grant=%b en=%b busy=%b want 0/0/0", bus.grant, bus.ff_enable, bus.busy);
        end
        tick();
        tests++;
        if (bus.done !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_done: got %b want 0", bus.done);
        end
        reset = 1'b1;
        tick();
        tests++;
        if (bus.grant !== 4'b0001 || bus.grant_id !== 3'd0 || bus.ff_d !== 8'h11) begin
            fails++;
            $display("FAIL post_reset_grant: got grant=%b id=%0d d=%h want 0001/0/11", bus.grant, bus.grant_id, bus.ff_d);
        end
        tick();
        tick();
        tests++;
        if (bus.done !== 1'b1 || bus.err !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_done: got done=%b err=%b want 1/0", bus.done, bus.err);
        end
        bus.req = '0;
        tick();
        ptr_m = 0;
    endtask

    task automatic test_single();
        bus.req_data = 32'h77A56655;
        bus.req = 4'b0100;
        tick();
        tests++;
        if (bus.grant !== 4'b0100 || bus.grant_id !== 3'd2 || bus.ff_d !== 8'hA5 ||
            bus.ff_enable !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL single_grant: got grant=%b id=%0d d=%h en=%b busy=%b done=%b want 0100/2/a5/1/1/0",
                     bus.grant, bus.grant_id, bus.ff_d, bus.ff_enable, bus.busy, bus.done);
        end
        tick();
        tests++;
        if (bus.ff_enable !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL single_verify: got en=%b busy=%b done=%b want 0/1/0", bus.ff_enable, bus.busy, bus.done);
        end
        tick();
        tests++;
        if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.grant !== 4'b0100 || bus.ff_enable !== 1'b0) begin
            fails++;
            $display("FAIL single_done: got done=%b err=%b grant=%b en=%b want 1/0/0100/0",
                     bus.done, bus.err, bus.grant, bus.ff_enable);
        end
        bus.req = '0;
        tick();
        tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.grant !== 4'b0000 ||
            bus.ff_d !== 8'hA5 || bus.grant_id !== 3'd2) begin
            fails++;
            $display("FAIL single_idle: got done=%b busy=%b grant=%b d=%h id=%0d want 0/0/0000/a5/2",
                     bus.done, bus.busy, bus.grant, bus.ff_d, bus.grant_id);
        end
        ptr_m = 2;
    endtask

    task automatic test_round_robin();
        int seq [5] = '{0, 1, 2, 3, 0};
        int last_cyc;
        logic [NUM_REQ-1:0] oh;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        ptr_m = NUM_REQ - 1;
        bus.req_data = 32'h13121110;
        bus.req = 4'b1111;
        last_cyc = 0;
        for (int t = 0; t < 5; t++) begin
            tick();
            oh = 4'b0001 << seq[t];
            tests++;
            if (bus.grant_id !== ID_W'(seq[t]) || bus.grant !== oh || bus.ff_d !== 8'(8'h10 + seq[t])) begin
                fails++;
                $display("FAIL rr_grant[%0d]: got id=%0d grant=%b d=%h want %0d/%b/%h",
                         t, bus.grant_id, bus.grant, bus.ff_d, seq[t], oh, 8'(8'h10 + seq[t]));
            end
            if (t > 0) begin
                tests++;
                if (cyc - last_cyc != 4) begin
                    fails++;
                    $display("FAIL rr_spacing[%0d]: got %0d cycles want 4", t, cyc - last_cyc);
                end
            end
            last_cyc = cyc;
            tick();
            tick();
            tests++;
            if (bus.done !== 1'b1 || bus.err !== 1'b0) begin
                fails++;
                $display("FAIL rr_done[%0d]: got done=%b err=%b want 1/0", t, bus.done, bus.err);
            end
            bus.req[seq[t]] = 1'b0;
            tick();
            bus.req[seq[t]] = 1'b1;
        end
        bus.req = '0;
        tick();
        ptr_m = 0;
    endtask

    task automatic test_fairness_skip();
        int seq [3] = '{3, 0, 1};
        bus.req_data = 32'hD3C2B1A0;
        bus.req = 4'b0010;
        tick();
        tick();
        tick();
        tests++;
        if (bus.grant_id !== 3'd1 || bus.done !== 1'b1) begin
            fails++;
            $display("FAIL skip_setup: got id=%0d done=%b want 1/1", bus.grant_id, bus.done);
        end
        bus.req = '0;
        tick();
        bus.req = 4'b1011;
        for (int t = 0; t < 3; t++) begin
            tick();
            tests++;
            if (bus.grant_id !== ID_W'(seq[t]) || bus.grant !== (4'b0001 << seq[t])) begin
                fails++;
                $display("FAIL skip_grant[%0d]: got id=%0d grant=%b want %0d", t, bus.grant_id, bus.grant, seq[t]);
            end
            tick();
            tick();
            bus.req[seq[t]] = 1'b0;
            tick();
            bus.req[seq[t]] = 1'b1;
        end
        bus.req = '0;
        tick();
        ptr_m = 1;
    endtask

    task automatic test_readback_fault();
        stuck = 1'b1;
        set_data(3, 8'h3C);
        bus.req = 4'b1000;
        tick();
        tests++;
        if (bus.grant !== 4'b1000 || bus.ff_d !== 8'h3C) begin
            fails++;
            $display("FAIL fault_grant: got grant=%b d=%h want 1000/3c", bus.grant, bus.ff_d);
        end
        tick();
        tick();
        tests++;
        if (bus.done !== 1'b1 || bus.err !== 1'b1) begin
            fails++;
            $display("FAIL fault_err: got done=%b err=%b want 1/1", bus.done, bus.err);
        end
        bus.req = '0;
        tick();
        tests++;
        if (bus.err !== 1'b0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL fault_clear: got done=%b err=%b want 0/0", bus.done, bus.err);
        end
        stuck = 1'b0;
        ptr_m = 3;
    endtask

    task automatic test_mid_change();
        set_data(1, 8'h5A);
        bus.req = 4'b0010;
        tick();
        tick();
        set_data(1, 8'hFF);
        bus.req[1] = 1'b0;
        tick();
        tests++;
        if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.ff_d !== 8'h5A || bus.grant !== 4'b0010) begin
            fails++;
            $display("FAIL mid_change: got done=%b err=%b d=%h grant=%b want 1/0/5a/0010",
                     bus.done, bus.err, bus.ff_d, bus.grant);
        end
        tick();
        tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.ff_d !== 8'h5A) begin
            fails++;
            $display("FAIL mid_idle: got done=%b busy=%b d=%h want 0/0/5a", bus.done, bus.busy, bus.ff_d);
        end
        ptr_m = 1;
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] pend;
        logic [DATA_W-1:0]  data_m [NUM_REQ];
        logic [DATA_W-1:0]  exp_d;
        logic               exp_err;
        logic               stuck_t;
        int                 w;
        pend = '0;
        for (int i = 0; i < NUM_REQ; i++) data_m[i] = '0;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]   = 1'b1;
                    data_m[i] = 8'($urandom);
                end
            end
            if (pend == '0) begin
                w = $urandom_range(0, NUM_REQ - 1);
                pend[w]   = 1'b1;
                data_m[w] = 8'($urandom);
            end
            for (int i = 0; i < NUM_REQ; i++) set_data(i, data_m[i]);
            bus.req = pend;
            stuck_t = ($urandom_range(0, 4) == 0);
            stuck   = stuck_t;
            w       = rr_pick(ptr_m, pend);
            exp_d   = data_m[w];
            exp_err = stuck_t ? (exp_d != 8'h00) : 1'b0;
            tick();
            tests++;
            if (bus.grant !== (4'b0001 << w) || bus.grant_id !== ID_W'(w) ||
                bus.ff_d !== exp_d || bus.ff_enable !== 1'b1) begin
                fails++;
                $display("FAIL rand_grant[%0d]: got grant=%b id=%0d d=%h en=%b want id=%0d d=%h en=1",
                         n, bus.grant, bus.grant_id, bus.ff_d, bus.ff_enable, w, exp_d);
            end
            tick();
            tests++;
            if (bus.ff_enable !== 1'b0 || !$onehot(bus.grant) || bus.done !== 1'b0) begin
                fails++;
                $display("FAIL rand_verify[%0d]: got en=%b grant=%b done=%b want 0/onehot/0",
                         n, bus.ff_enable, bus.grant, bus.done);
            end
            for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'($urandom));
            tick();
            tests++;
            if (bus.done !== 1'b1 || bus.err !== exp_err || bus.ff_d !== exp_d || bus.grant !== (4'b0001 << w)) begin
                fails++;
                $display("FAIL rand_done[%0d]: got done=%b err=%b d=%h grant=%b want 1/%b/%h/id %0d",
                         n, bus.done, bus.err, bus.ff_d, bus.grant, exp_err, exp_d, w);
            end
            pend[w] = 1'b0;
            bus.req = pend;
            ptr_m   = w;
            for (int i = 0; i < NUM_REQ; i++) set_data(i, data_m[i]);
            tick();
            tests++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.grant !== '0 || bus.ff_enable !== 1'b0) begin
                fails++;
                $display("FAIL rand_idle[%0d]: got done=%b busy=%b grant=%b en=%b want 0/0/0000/0",
                         n, bus.done, bus.busy, bus.grant, bus.ff_enable);
            end
            stuck = 1'b0;
        end
        bus.req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness_skip();
        test_readback_fault();
        test_mid_change();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
